con_scan_ctrl: RTL and testbench

Sequencer for the 7x7 convolution datapath (`con`). It walks the 7x7 kernel window over a feature map of configurable size in raster order with stride 1, one window per issue cycle. It issues a fire strobe plus window coordinates to the window-fetch logic, limits in-flight results with a credit counter toward the downstream result buffer, and realigns position/valid/last tags with `out_reg` after the fixed datapath latency.

---
 rtl/con_pkg.sv | 22 ++
 rtl/con_scan_ctrl_if.sv | 32 +++
 rtl/con_tag_pipe.sv | 32 +++
 rtl/con_scan_ctrl.sv | 116 +++++++++++
 tb/tb_con_scan_ctrl.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/con_pkg.sv
// Shared constants, FSM state encoding and the tag record for the 7x7 convolution
// scan sequencer.
package con_pkg;
    localparam int K            = 7;
    localparam int CON_COORD_W  = 8;
    localparam int PIPE_LAT_DEF = 8;
    localparam int CREDITS_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } con_scan_state_t;

    typedef struct packed {
        logic                   valid;
        logic [CON_COORD_W-1:0] row;
        logic [CON_COORD_W-1:0] col;
        logic                   last;
    } con_tag_t;
endpackage

// File: rtl/con_scan_ctrl_if.sv
// Control, window-issue and result-tag signals between the scan sequencer and
// the rest of the convolution datapath.
interface con_scan_ctrl_if #(
    parameter int COORD_W = 8
);
    logic               start;
    logic [COORD_W-1:0] cfg_w;
    logic [COORD_W-1:0] cfg_h;
    logic               credit_ret;
    logic               busy;
    logic               done;
    logic               err;
    logic               win_valid;
    logic [COORD_W-1:0] win_row;
    logic [COORD_W-1:0] win_col;
    logic               out_valid;
    logic [COORD_W-1:0] out_row;
    logic [COORD_W-1:0] out_col;
    logic               out_last;

    modport master (
        input  start, cfg_w, cfg_h, credit_ret,
        output busy, done, err, win_valid, win_row, win_col,
               out_valid, out_row, out_col, out_last
    );

    modport slave (
        output start, cfg_w, cfg_h, credit_ret,
        input  busy, done, err, win_valid, win_row, win_col,
               out_valid, out_row, out_col, out_last
    );
endinterface

// File: rtl/con_tag_pipe.sv
// Fixed-latency shift register that carries issue tags alongside the datapath
// so results come out labelled with their output-map position.
module con_tag_pipe
    import con_pkg::*;
#(
    parameter int DEPTH = PIPE_LAT_DEF
) (
    input  logic     clk,
    input  logic     rst,
    input  con_tag_t din,
    output con_tag_t dout,
    output logic     pending
);
    con_tag_t stage [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[DEPTH-1];

    // Output stage excluded: lets the frame finish the cycle after the last result.
    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) pending = pending | stage[i].valid;
    end
endmodule

// File: rtl/con_scan_ctrl.sv
// Raster-order 7x7 window sequencer with credit-limited issue and tag realignment.
//   state | meaning
//   IDLE  | wait for start
//   RUN   | issue one window per cycle while credit is available
//   DRAIN | wait for in-flight tags to reach the output; also the reject path
//   DONE  | one-cycle completion pulse
module con_scan_ctrl #(
    parameter int K        = con_pkg::K,
    parameter int COORD_W  = con_pkg::CON_COORD_W,
    parameter int PIPE_LAT = con_pkg::PIPE_LAT_DEF,
    parameter int CREDITS  = con_pkg::CREDITS_DEF
) (
    input logic             clk,
    input logic             rst,
    con_scan_ctrl_if.master bus
);
    import con_pkg::*;

    localparam int CRED_W = $clog2(CREDITS + 1);
    localparam logic [1:0] S_IDLE  = 2'(IDLE);
    localparam logic [1:0] S_RUN   = 2'(RUN);
    localparam logic [1:0] S_DRAIN = 2'(DRAIN);
    localparam logic [1:0] S_DONE  = 2'(DONE);
    localparam logic [COORD_W-1:0] K_C       = COORD_W'(K);
    localparam logic [CRED_W-1:0]  CRED_FULL = CRED_W'(CREDITS);

    logic [1:0]         state;
    logic [COORD_W-1:0] row, col, row_max, col_max;
    logic [CRED_W-1:0]  credit;
    logic               cfg_bad, err_q;
    logic               accept, cfg_invalid, issue, last_issue, pending;
    con_tag_t           tag_in, tag_out;

    assign accept      = (state == S_IDLE) && bus.start;
    assign cfg_invalid = (bus.cfg_w < K_C) || (bus.cfg_h < K_C);
    assign issue       = (state == S_RUN) && (credit != '0);
    assign last_issue  = (row == row_max) && (col == col_max);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            row     <= '0;
            col     <= '0;
            row_max <= '0;
            col_max <= '0;
            cfg_bad <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (bus.start) begin
                    row     <= '0;
                    col     <= '0;
                    row_max <= bus.cfg_h - K_C;
                    col_max <= bus.cfg_w - K_C;
                    cfg_bad <= cfg_invalid;
                    err_q   <= 1'b0;
                    state   <= cfg_invalid ? S_DRAIN : S_RUN;
                end
                S_RUN: if (issue) begin
                    if (col == col_max) begin
                        col <= '0;
                        if (row == row_max) state <= S_DRAIN;
                        else                row   <= row + 1'b1;
                    end else begin
                        col <= col + 1'b1;
                    end
                end
                S_DRAIN: if (!pending) begin
                    state <= S_DONE;
                    err_q <= cfg_bad;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Simultaneous issue and return cancel; returns beyond a full buffer are dropped.
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            credit <= CRED_FULL;
        end else begin
            case ({issue, bus.credit_ret})
                2'b10:   credit <= credit - 1'b1;
                2'b01:   if (credit != CRED_FULL) credit <= credit + 1'b1;
                default: credit <= credit;
            endcase
        end
    end

    always_comb begin
        tag_in       = '0;
        tag_in.valid = issue;
        tag_in.row   = issue ? CON_COORD_W'(row) : '0;
        tag_in.col   = issue ? CON_COORD_W'(col) : '0;
        tag_in.last  = issue && last_issue;
    end

    con_tag_pipe #(.DEPTH(PIPE_LAT)) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .din     (tag_in),
        .dout    (tag_out),
        .pending (pending)
    );

    assign bus.busy      = (state == S_RUN) || (state == S_DRAIN);
    assign bus.done      = (state == S_DONE);
    assign bus.err       = err_q;
    assign bus.win_valid = issue;
    assign bus.win_row   = row;
    assign bus.win_col   = col;
    assign bus.out_valid = tag_out.valid;
    assign bus.out_row   = COORD_W'(tag_out.row);
    assign bus.out_col   = COORD_W'(tag_out.col);
    assign bus.out_last  = tag_out.last;
endmodule

// File: tb/tb_con_scan_ctrl.sv
// Bench for con_scan_ctrl: directed and randomized frames checked cycle by cycle
// against a window-list / credit-count / latency-queue model.
module tb_con_scan_ctrl;
    localparam int LAT  = 8;
    localparam int CRED = 8;
    localparam int KK   = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    con_scan_ctrl_if #(.COORD_W(8)) bus ();
    con_scan_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        int row;
        int col;
        bit last;
        int due;
    } exp_t;

    exp_t win_q[$];
    exp_t out_q[$];
    int   nvec = 0, nfail = 0, cyc = 0;
    int   done_at = -1, err_at = -1, m_credit = CRED, dut_issues = 0, base = 0;
    bit   m_busy = 0, m_err = 0, m_run = 0, chk_zero = 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Check this cycle's outputs, drive this cycle's inputs, advance model one clock.
    task automatic step(input bit st, input int w, input int h, input bit ret, input bit rs);
        bit   exp_wv, exp_ov, exp_done, accept;
        exp_t e;
        exp_wv = m_run && (m_credit > 0);
        chk("win_valid", 32'(bus.win_valid), 32'(exp_wv));
        if (exp_wv) begin
            chk("win_row", 32'(bus.win_row), 32'(win_q[0].row));
            chk("win_col", 32'(bus.win_col), 32'(win_q[0].col));
        end
        exp_ov = (out_q.size() > 0) && (out_q[0].due == cyc);
        chk("out_valid", 32'(bus.out_valid), 32'(exp_ov));
        if (exp_ov) begin
            chk("out_row", 32'(bus.out_row), 32'(out_q[0].row));
            chk("out_col", 32'(bus.out_col), 32'(out_q[0].col));
            chk("out_last", 32'(bus.out_last), 32'(out_q[0].last));
        end
        exp_done = (cyc == done_at);
        chk("done", 32'(bus.done), 32'(exp_done));
        chk("busy", 32'(bus.busy), 32'(m_busy));
        chk("err", 32'(bus.err), 32'(m_err));
        if (chk_zero) begin
            chk("zero_win_row", 32'(bus.win_row), 0);
            chk("zero_win_col", 32'(bus.win_col), 0);
            chk("zero_out_row", 32'(bus.out_row), 0);
            chk("zero_out_col", 32'(bus.out_col), 0);
            chk("zero_out_last", 32'(bus.out_last), 0);
            chk_zero = 0;
        end
        if (bus.win_valid === 1'b1) dut_issues++;

        bus.start      = st;
        bus.cfg_w      = 8'(w);
        bus.cfg_h      = 8'(h);
        bus.credit_ret = ret;
        rst            = rs;

        if (rs) begin
            win_q.delete();
            out_q.delete();
            m_run = 0; m_busy = 0; m_err = 0; m_credit = CRED;
            done_at = -1; err_at = -1; chk_zero = 1;
        end else begin
            accept = st && !m_busy && !exp_done;
            if (exp_wv) begin
                e = win_q.pop_front();
                e.due = cyc + LAT;
                out_q.push_back(e);
                if (win_q.size() == 0) m_run = 0;
            end
            if (accept)                                  m_credit = CRED;
            else if (exp_wv && !ret)                     m_credit--;
            else if (ret && !exp_wv && m_credit < CRED)  m_credit++;
            if (exp_ov) begin
                e = out_q.pop_front();
                if (e.last) done_at = cyc + 1;
            end
            if (accept) begin
                m_busy = 1;
                m_err  = 0;
                if (w < KK || h < KK) begin
                    done_at = cyc + 2;
                    err_at  = cyc + 2;
                end else begin
                    for (int r = 0; r <= h - KK; r++)
                        for (int c = 0; c <= w - KK; c++)
                            win_q.push_back('{r, c, (r == h - KK) && (c == w - KK), 0});
                    m_run = 1;
                end
            end
            if (cyc + 1 == done_at) m_busy = 0;
            if (cyc + 1 == err_at)  m_err  = 1;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic bit pick_ret(input int mode);
        if (mode == 0) return 1'b0;
        if (mode == 1) return 1'b1;
        return 1'($urandom_range(0, 1));
    endfunction

    // Idle cycles with junk config until the frame's done pulse has passed.
    task automatic run_frame(input int budget, input int mode);
        for (int i = 0; i < budget && (m_busy || done_at >= cyc); i++)
            step(0, $urandom_range(0, 255), $urandom_range(0, 255), pick_ret(mode), 0);
        nvec++;
        assert (!(m_busy || done_at >= cyc)) else begin
            nfail++;
            $error("FAIL frame_timeout: observed busy after %0d cycles expected idle", budget);
        end
    endtask

    initial begin
        bus.start = 0; bus.cfg_w = 0; bus.cfg_h = 0; bus.credit_ret = 0;
        @(posedge clk);
        #1;
        cyc = 1;
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);

        // 9x9, returns always on: 3x3 windows gap-free
        base = dut_issues;
        step(1, 9, 9, 1, 0);
        run_frame(100, 1);
        chk("issues_9x9", 32'(dut_issues - base), 9);

        // 28x28: stall at 8 with no returns, then one issue per return
        base = dut_issues;
        step(1, 28, 28, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 3, 3, 0, 0);
        chk("issues_stall", 32'(dut_issues - base), 8);
        for (int i = 0; i < 5; i++) begin
            step(0, 3, 3, 1, 0);
            for (int j = 0; j < 3; j++) step(0, 3, 3, 0, 0);
        end
        chk("issues_per_ret", 32'(dut_issues - base), 13);
        for (int i = 0; i < 8; i++) step(0, 3, 3, 1, 0);
        chk("issues_credit1", 32'(dut_issues - base), 20);
        run_frame(3000, 2);
        chk("issues_28x28", 32'(dut_issues - base), 484);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0);

        // rejected size, then minimum legal size clears err
        base = dut_issues;
        step(1, 6, 9, 0, 0);
        run_frame(10, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
        chk("issues_bad", 32'(dut_issues - base), 0);
        step(1, 7, 7, 1, 0);
        run_frame(50, 1);
        chk("issues_7x7", 32'(dut_issues - base), 1);

        // reset after 50 windows of a 20x20 frame, then restart
        base = dut_issues;
        step(1, 20, 20, 1, 0);
        for (int i = 0; i < 200 && dut_issues - base < 50; i++) step(0, 0, 0, 1, 0);
        chk("rst_at_50", 32'(dut_issues - base), 50);
        step(0, 0, 0, 1, 1);
        for (int i = 0; i < LAT + 4; i++) step(0, 0, 0, 1, 0);
        step(1, 9, 8, 1, 0);
        run_frame(200, 2);

        // start while running is ignored
        base = dut_issues;
        step(1, 10, 9, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
        step(1, 20, 9, 1, 0);
        run_frame(200, 1);
        chk("issues_ignore", 32'(dut_issues - base), 12);

        // random frames
        for (int f = 0; f < 6; f++) begin
            step(1, $urandom_range(5, 14), $urandom_range(6, 13), pick_ret(2), 0);
            run_frame(2000, 2);
            step(0, 0, 0, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
